swipt_data_tx: RTL

Serial frame transmitter for the SWIPT data link: takes an 8-bit payload, wraps it in the team's 36-bit frame (header, reserved field, Manchester-paired data, trailer) and drives it MSB-first on a single line `dout`, one bit per `BIT_PERIOD` clocks. It is the transmit end of the same one-wire protocol decoded by the link receiver. Its frame format and bit timing therefore match the receiver exactly: idle-low line, first rising edge starts the frame, bit period 200000 clocks.

---
 rtl/swipt_data_tx_if.sv | 20 ++
 rtl/swipt_data_tx.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/swipt_data_tx_if.sv
// Handshake and serial-line bundle between a frame source and the SWIPT data transmitter.
interface swipt_data_tx_if;
  logic       swiptAlive;
  logic       send;
  logic [7:0] dataOut;
  logic       dout;
  logic       busy;
  logic       done;
  logic [7:0] onesCount;

  modport master (
    output swiptAlive, send, dataOut,
    input  dout, busy, done, onesCount
  );

  modport slave (
    input  swiptAlive, send, dataOut,
    output dout, busy, done, onesCount
  );
endinterface

// File: rtl/swipt_data_tx.sv
// SWIPT one-wire frame transmitter: 36-bit frame (header, reserved, Manchester-paired
// payload, trailer) shifted MSB-first, BIT_PERIOD clocks per bit, then an idle gap.
module swipt_data_tx #(
  parameter int unsigned BIT_PERIOD = 200000,
  parameter int unsigned GAP_BITS   = 2
) (
  input logic            clk,
  input logic            nrst,
  swipt_data_tx_if.slave bus
);

  localparam int unsigned FRAME_BITS = 36;
  localparam int unsigned PW         = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int unsigned GAP_CYC    = GAP_BITS * BIT_PERIOD;
  localparam int unsigned GW         = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned BW         = 6;
  localparam int unsigned OW         = 8;

  localparam logic [PW-1:0] PER_LOAD = PW'(BIT_PERIOD - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);
  localparam logic [BW-1:0] BIT_LOAD = BW'(FRAME_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]            r_state, w_state_nxt;
  logic [FRAME_BITS-1:0] r_shift, w_shift_nxt;
  logic                  r_dout,  w_dout_nxt;
  logic                  r_busy,  w_busy_nxt;
  logic                  r_done,  w_done_nxt;
  logic [OW-1:0]         r_ones,  w_ones_nxt;
  logic [BW-1:0]         r_bit,   w_bit_nxt;
  logic [PW-1:0]         r_per,   w_per_nxt;
  logic [GW-1:0]         r_gap,   w_gap_nxt;
  logic [FRAME_BITS-1:0] w_frame;

  // Frame layout: 101010 | 8 x 0 | {~d[k], d[k]} pairs, d[7] pair first | 00 | 0101
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] d);
    logic [FRAME_BITS-1:0] f;
    f        = '0;
    f[35:30] = 6'b101010;
    for (int k = 0; k < 8; k++) begin
      f[2*k+6] = d[k];
      f[2*k+7] = ~d[k];
    end
    f[3:0]   = 4'b0101;
    return f;
  endfunction

  always_ff @(posedge clk) begin
    if (!nrst || !bus.swiptAlive) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_dout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ones  <= '0;
      r_bit   <= '0;
      r_per   <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_dout  <= w_dout_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ones  <= w_ones_nxt;
      r_bit   <= w_bit_nxt;
      r_per   <= w_per_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_dout_nxt  = r_dout;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_ones_nxt  = r_ones;
    w_bit_nxt   = r_bit;
    w_per_nxt   = r_per;
    w_gap_nxt   = r_gap;
    w_frame     = build_frame(bus.dataOut);

    case (r_state)
      S_IDLE: begin
        w_dout_nxt = 1'b0;
        w_busy_nxt = 1'b0;
        if (bus.send) begin
          w_shift_nxt = w_frame;
          w_dout_nxt  = w_frame[FRAME_BITS-1];
          w_busy_nxt  = 1'b1;
          w_ones_nxt  = OW'(w_frame[FRAME_BITS-1]);
          w_bit_nxt   = BIT_LOAD;
          w_per_nxt   = PER_LOAD;
          w_state_nxt = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (r_per != '0) begin
          w_per_nxt = r_per - 1'b1;
        end else if (r_bit != '0) begin
          w_shift_nxt = {r_shift[FRAME_BITS-2:0], 1'b0};
          w_dout_nxt  = r_shift[FRAME_BITS-2];
          w_ones_nxt  = r_ones + OW'(r_shift[FRAME_BITS-2]);
          w_per_nxt   = PER_LOAD;
          w_bit_nxt   = r_bit - 1'b1;
        end else if (GAP_CYC == 0) begin
          w_dout_nxt  = 1'b0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_dout_nxt  = 1'b0;
          w_gap_nxt   = GAP_LOAD;
          w_state_nxt = S_GAP;
        end
      end

      S_GAP: begin
        w_dout_nxt = 1'b0;
        if (r_gap != '0) begin
          w_gap_nxt = r_gap - 1'b1;
        end else begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_dout_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.dout      = r_dout;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.onesCount = r_ones;

endmodule
